// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - hz_state_e             : controller FSM state encoding
//   - DEFAULT_TIMEOUT_CYCLES : default freeze-length limit before a hang is declared
//   - load_use_hazard()      : load-use detection between ID/EX and IF/ID
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HUNG   = 2'd2
  } hz_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic load_use_hazard(
    input logic       memread,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter32.sv
// -----------------------------------------------------------------------------
// sat_counter32
// 32-bit event counter that increments on every enabled clock edge and sticks
// at 0xFFFFFFFF instead of wrapping.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset, clears the count
//   en_i     : count this cycle
//   count_o  : current count
// -----------------------------------------------------------------------------
module sat_counter32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard/stall/flush controller for a 5-stage pipeline. Handles data-memory
// back-pressure (whole-pipe freeze), taken branches (IF/ID + ID/EX flush) and
// load-use hazards (one-cycle stall with bubble). A freeze that lasts
// TIMEOUT_CYCLES cycles is declared hung and only reset recovers it.
//
// Ports:
//   clk            : pipeline clock, rising edge
//   reset          : asynchronous active-low reset
//   IDEX_MemRead   : ID/EX instruction is a load
//   IDEX_rd        : ID/EX destination register
//   IFID_rs1/rs2   : IF/ID source registers
//   branch_taken   : EX-stage branch/jump resolved taken
//   dmem_busy      : data memory cannot complete this cycle
//   PCWrite        : PC load enable
//   IFID_stall     : hold IF/ID
//   IFID_flush     : flush IF/ID
//   IDEX_flush     : bubble into ID/EX
//   pipe_freeze    : hold ID/EX, EX/MEM, MEM/WB
//   stall_cycles   : saturating count of cycles with PCWrite=0
//   flush_events   : saturating count of cycles with IFID_flush=1
//   timeout_err    : sticky freeze-timeout flag
//   dbg_state_o    : current FSM state (hz_state_e encoding)
//
// Handshake/timing: every control output is combinational from the registered
// state and the current-cycle inputs; counters and state update on the rising
// edge that ends the cycle the outputs describe.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rd,
  input  logic [4:0]  IFID_rs1,
  input  logic [4:0]  IFID_rs2,
  input  logic        branch_taken,
  input  logic        dmem_busy,
  output logic        PCWrite,
  output logic        IFID_stall,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        pipe_freeze,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic        timeout_err,
  output logic [1:0]  dbg_state_o
);

  // Freeze counter must hold TIMEOUT_CYCLES itself; never narrower than 8 bits.
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

  localparam logic [CW:0] TMO_LIMIT = (CW + 1)'(TIMEOUT_CYCLES);
  // With a limit of 0 or 1 the very first busy cycle already exhausts it.
  localparam bit FIRST_CYCLE_TIMES_OUT = (TIMEOUT_CYCLES <= 1);

  hz_state_e      state_q;
  logic [CW-1:0]  frz_cnt_q;
  logic           timeout_q;

  logic           load_use;
  logic           hold_frozen;
  logic [CW:0]    frz_inc;

  assign load_use = load_use_hazard(IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2);

  // HUNG always freezes; FREEZE freezes only while memory is still busy. When
  // FREEZE sees busy drop, this cycle is evaluated with RUN rules below.
  assign hold_frozen = (state_q == ST_HUNG) ||
                       ((state_q == ST_FREEZE) && dmem_busy);

  assign frz_inc = {1'b0, frz_cnt_q} + {{CW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite     = 1'b1;
    IFID_stall  = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (hold_frozen || dmem_busy) begin
      // Memory back-pressure beats everything, including a taken branch.
      PCWrite     = 1'b0;
      IFID_stall  = 1'b1;
      pipe_freeze = 1'b1;
    end else if (branch_taken) begin
      // The flush removes the dependent instruction, so any load-use is moot.
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
    end else if (load_use) begin
      PCWrite     = 1'b0;
      IFID_stall  = 1'b1;
      IDEX_flush  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state, freeze-length counter and sticky timeout flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      frz_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dmem_busy) begin
            frz_cnt_q <= CW'(1);
            if (FIRST_CYCLE_TIMES_OUT) begin
              state_q   <= ST_HUNG;
              timeout_q <= 1'b1;
            end else begin
              state_q   <= ST_FREEZE;
            end
          end
        end
        ST_FREEZE: begin
          if (dmem_busy) begin
            // Counter stays below the limit while in FREEZE, so frz_inc fits.
            frz_cnt_q <= frz_inc[CW-1:0];
            if (frz_inc >= TMO_LIMIT) begin
              state_q   <= ST_HUNG;
              timeout_q <= 1'b1;
            end
          end else begin
            state_q   <= ST_RUN;
            frz_cnt_q <= '0;
          end
        end
        ST_HUNG: begin
          // Only reset leaves HUNG.
          timeout_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_RUN;
          frz_cnt_q <= '0;
        end
      endcase
    end
  end

  assign timeout_err = timeout_q;
  assign dbg_state_o = state_q;

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  sat_counter32 u_stall_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (~PCWrite),
    .count_o (stall_cycles)
  );

  sat_counter32 u_flush_cnt (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (IFID_flush),
    .count_o (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int TMO = 256;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        reset;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_rd;
  logic [4:0]  IFID_rs1;
  logic [4:0]  IFID_rs2;
  logic        branch_taken;
  logic        dmem_busy;
  logic        PCWrite;
  logic        IFID_stall;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        pipe_freeze;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .IDEX_MemRead (IDEX_MemRead),
    .IDEX_rd      (IDEX_rd),
    .IFID_rs1     (IFID_rs1),
    .IFID_rs2     (IFID_rs2),
    .branch_taken (branch_taken),
    .dmem_busy    (dmem_busy),
    .PCWrite      (PCWrite),
    .IFID_stall   (IFID_stall),
    .IFID_flush   (IFID_flush),
    .IDEX_flush   (IDEX_flush),
    .pipe_freeze  (pipe_freeze),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .timeout_err  (timeout_err),
    .dbg_state_o  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  // Model: "in a freeze episode", its length so far, hung, sticky error, counts.
  bit     m_frozen, m_hung, m_err;
  int     m_len;
  longint m_stall, m_flush;
  logic   e_pc, e_st, e_iff, e_idf, e_frz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_frozen = 0; m_hung = 0; m_err = 0; m_len = 0; m_stall = 0; m_flush = 0;
  endtask

  // Expected control outputs for the current cycle from the rules.
  task automatic model_outputs();
    bit lu;
    lu = IDEX_MemRead && (IDEX_rd != 0) && ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
    {e_pc, e_st, e_iff, e_idf, e_frz} = 5'b1_0_0_0_0;
    if (m_hung || dmem_busy)  {e_pc, e_st, e_iff, e_idf, e_frz} = 5'b0_1_0_0_1;
    else if (branch_taken)    {e_pc, e_st, e_iff, e_idf, e_frz} = 5'b1_0_1_1_0;
    else if (lu)              {e_pc, e_st, e_iff, e_idf, e_frz} = 5'b0_1_0_1_0;
  endtask

  task automatic model_advance(input bit busy);
    if (!e_pc && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (e_iff && m_flush < 64'hFFFF_FFFF) m_flush++;
    if (!m_hung) begin
      if (busy) begin
        m_len    = m_frozen ? m_len + 1 : 1;
        m_frozen = 1;
        if (m_len >= TMO) begin m_hung = 1; m_err = 1; end
      end else begin
        m_frozen = 0; m_len = 0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one pipeline cycle; starts and ends 1 time unit after a rising edge
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit br, input bit busy);
    IDEX_MemRead = mr; IDEX_rd = rd; IFID_rs1 = rs1; IFID_rs2 = rs2;
    branch_taken = br; dmem_busy = busy;
    #2;
    model_outputs();
    check("PCWrite",     {31'd0, PCWrite},     {31'd0, e_pc});
    check("IFID_stall",  {31'd0, IFID_stall},  {31'd0, e_st});
    check("IFID_flush",  {31'd0, IFID_flush},  {31'd0, e_iff});
    check("IDEX_flush",  {31'd0, IDEX_flush},  {31'd0, e_idf});
    check("pipe_freeze", {31'd0, pipe_freeze}, {31'd0, e_frz});
    @(posedge clk);
    #1;
    model_advance(busy);
    check("stall_cycles", stall_cycles, m_stall[31:0]);
    check("flush_events", flush_events, m_flush[31:0]);
    check("timeout_err",  {31'd0, timeout_err}, {31'd0, m_err});
  endtask

  // Asynchronous reset in the middle of a cycle, then release after one edge.
  task automatic mid_cycle_reset(input string tag);
    IDEX_MemRead = 0; IDEX_rd = 0; IFID_rs1 = 0; IFID_rs2 = 0;
    branch_taken = 0; dmem_busy = 0;
    #3;
    reset = 1'b0;
    #1;
    check({tag, "_stall0"},   stall_cycles, 32'd0);
    check({tag, "_flush0"},   flush_events, 32'd0);
    check({tag, "_tmo0"},     {31'd0, timeout_err}, 32'd0);
    check({tag, "_pcwrite"},  {31'd0, PCWrite}, 32'd1);
    check({tag, "_freeze"},   {31'd0, pipe_freeze}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check({tag, "_held"},     stall_cycles, 32'd0);
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] s0, f0;
    reset = 1'b0;
    IDEX_MemRead = 0; IDEX_rd = 0; IFID_rs1 = 0; IFID_rs2 = 0;
    branch_taken = 0; dmem_busy = 0;
    model_reset();
    #1;
    check("rst_pcwrite", {31'd0, PCWrite}, 32'd1);
    check("rst_stall",   stall_cycles, 32'd0);
    check("rst_flush",   flush_events, 32'd0);
    check("rst_tmo",     {31'd0, timeout_err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Load-use on rs2: one stall cycle with bubble.
    s0 = stall_cycles;
    cycle(1, 5'd5, 5'd1, 5'd5, 0, 0);
    check("lu_stall_delta", stall_cycles - s0, 32'd1);
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 0);

    // Same pattern with rd = x0: no hazard.
    s0 = stall_cycles;
    cycle(1, 5'd0, 5'd0, 5'd0, 0, 0);
    check("x0_stall_delta", stall_cycles - s0, 32'd0);

    // Branch coincident with load-use: branch wins.
    s0 = stall_cycles; f0 = flush_events;
    cycle(1, 5'd7, 5'd7, 5'd3, 1, 0);
    check("br_lu_flush_delta", flush_events - f0, 32'd1);
    check("br_lu_stall_delta", stall_cycles - s0, 32'd0);

    // Four busy cycles with a taken branch throughout, then busy drops.
    s0 = stall_cycles; f0 = flush_events;
    for (int i = 0; i < 4; i++) cycle(1, 5'd2, 5'd2, 5'd0, 1, 1);
    check("busy_no_flush", flush_events - f0, 32'd0);
    cycle(0, 5'd0, 5'd0, 5'd0, 1, 0);
    check("busy_stall_delta", stall_cycles - s0, 32'd4);
    check("busy_flush_delta", flush_events - f0, 32'd1);
    check("back_to_run", {30'd0, dbg_state}, 32'd0);

    // Reset in the middle of a short freeze.
    for (int i = 0; i < 3; i++) cycle(0, 5'd0, 5'd0, 5'd0, 0, 1);
    mid_cycle_reset("rst_freeze");

    // Long busy: hang after exactly TMO freeze cycles, stays frozen afterwards.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
      if (i == TMO - 2) check("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
      if (i == TMO - 1) check("tmo_set",     {31'd0, timeout_err}, 32'd1);
    end
    for (int i = 0; i < 3; i++) cycle(1, 5'd4, 5'd4, 5'd0, 1, 0);
    check("hung_sticky", {31'd0, timeout_err}, 32'd1);
    check("hung_stall_total", stall_cycles, 32'd303);
    mid_cycle_reset("rst_hung");

    // Random traffic with occasional short busy bursts.
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
